seq_addsub: RTL

Parametrised digit-serial adder/subtractor: it adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using an internal chain of full adders that is DIGIT bits wide. Results are registered and handed back through a start/busy/done handshake. It is the multi-cycle, wide-operand successor to the fixed 4-bit ripple adder in the combinational library. Area is traded for latency, and the block adds carry-in, a subtract mode and a signed-overflow flag.

---
 rtl/seq_addsub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits of A and B' are summed per clock
// through a ripple chain, with results handed back via start/busy/done.
module seq_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_dsum;
  logic [DIGIT:0]   w_c;
  logic [WIDTH-1:0] w_dig_ext;
  logic [WIDTH-1:0] w_work_next;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

  // Operands shift right each RUN cycle, so the live digit is always bits [DIGIT-1:0].
  always_comb begin
    w_c    = '0;
    w_dsum = '0;
    w_c[0] = r_carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      w_dsum[i] = r_a[i] ^ r_b[i] ^ w_c[i];
      w_c[i+1]  = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
    end
  end

  // Finished digits enter at the top of the working register and drift down.
  always_comb begin
    w_dig_ext              = '0;
    w_dig_ext[DIGIT-1:0]   = w_dsum;
    w_work_next            = (r_work >> DIGIT) | (w_dig_ext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
    sum  = r_sum;
    cout = r_cout;
    ovf  = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
      r_work  <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      r_work  <= w_work_next;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= w_c[DIGIT];
        r_ovf  <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end
    end
  end

endmodule
